// File: rtl/vga_reg_bank.sv
// vga_reg_bank: draws NUM_REGS registers as hex text rows over the px_clk RGB stream.
// Optional VGA_REG_BANK_CHANGE_HL_EN: digits changed at a snapshot glow 3'b110 for 15 frames.
package vga_reg_bank_pkg;
    typedef struct packed {
        logic [22:0] vga;
        logic [2:0]  rgb;
        logic        hit;
        logic        hl;
        logic [3:0]  nib;
        logic [2:0]  line;
        logic [2:0]  col;
    } s1_t;
endpackage

module vga_reg_bank #(
    parameter int         NUM_REGS   = 4,
    parameter int         REG_WIDTH  = 16,
    parameter int         SCALE_LOG2 = 0,
    parameter logic [2:0] FG_COLOR   = 3'b111,
    parameter logic [2:0] BG_COLOR   = 3'b001,
    parameter bit         OPAQUE     = 1'b1
) (
    input  logic                          px_clk,
    input  logic                          rst_n,
    input  logic [25:0]                   strRGB_i,
    input  logic [9:0]                    x_pos,
    input  logic [9:0]                    y_pos,
    input  logic [NUM_REGS*REG_WIDTH-1:0] regs_i,
    output logic [25:0]                   strRGB_o,
    output logic                          snap_o
);
    import vga_reg_bank_pkg::*;

    localparam int          DIGITS   = (REG_WIDTH + 3) / 4;
    localparam int          PADW     = DIGITS * 4;
    localparam int          CELL     = 3 + SCALE_LOG2;
    localparam logic [10:0] BOX_W    = 11'((DIGITS * 8) << SCALE_LOG2);
    localparam logic [10:0] BOX_H    = 11'((NUM_REGS * 8) << SCALE_LOG2);
    localparam logic [2:0]  HL_COLOR = 3'b110;

    logic [PADW-1:0] snap  [NUM_REGS];
    logic [PADW-1:0] fresh [NUM_REGS];
    logic [9:0]      xp;
    logic [9:0]      yp;
    logic            vs_prev;
    logic            vs_rise;

    logic [22:0] vga;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] xp11;
    logic [10:0] yp11;
    logic        hit;
    logic [2:0]  row;
    logic [2:0]  dig;

    s1_t s1;
    s1_t s1_nx;

    logic [63:0] glyph;
    logic [7:0]  bits;
    logic        on;
    logic [2:0]  color;

    assign vga     = strRGB_i[25:3];
    assign x       = vga[9:0];
    assign y       = vga[19:10];
    assign vs_rise = vga[21] & ~vs_prev;

    // Top nibble is zero-padded when REG_WIDTH is not a multiple of 4.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++)
            fresh[k] = PADW'(regs_i[k*REG_WIDTH +: REG_WIDTH]);
    end

    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            vs_prev <= 1'b0;
            snap_o  <= 1'b0;
            xp      <= '0;
            yp      <= '0;
            for (int k = 0; k < NUM_REGS; k++)
                snap[k] <= '0;
        end else begin
            vs_prev <= vga[21];
            snap_o  <= vs_rise;
            if (vs_rise) begin
                xp <= x_pos;
                yp <= y_pos;
                for (int k = 0; k < NUM_REGS; k++)
                    snap[k] <= fresh[k];
            end
        end
    end

`ifdef VGA_REG_BANK_CHANGE_HL_EN
    // Indexed by nibble position, LSB nibble first.
    logic [3:0] hold [NUM_REGS][DIGITS];

    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++)
                for (int d = 0; d < DIGITS; d++)
                    hold[k][d] <= '0;
        end else if (vs_rise) begin
            for (int k = 0; k < NUM_REGS; k++)
                for (int d = 0; d < DIGITS; d++)
                    if (fresh[k][d*4 +: 4] != snap[k][d*4 +: 4])
                        hold[k][d] <= 4'd15;
                    else if (hold[k][d] != 4'd0)
                        hold[k][d] <= hold[k][d] - 4'd1;
        end
    end
`endif

    // 11-bit compares so boxes past column/line 1023 clip instead of wrapping.
    assign x11  = {1'b0, x};
    assign y11  = {1'b0, y};
    assign xp11 = {1'b0, xp};
    assign yp11 = {1'b0, yp};

    assign hit = vga[22]
               && (x11 >= xp11) && (x11 < xp11 + BOX_W)
               && (y11 >= yp11) && (y11 < yp11 + BOX_H);

    assign dx  = x - xp;
    assign dy  = y - yp;
    assign dig = 3'(dx >> CELL);
    assign row = 3'(dy >> CELL);

    always_comb begin
        s1_nx      = '0;
        s1_nx.vga  = vga;
        s1_nx.rgb  = strRGB_i[2:0];
        s1_nx.hit  = hit;
        s1_nx.line = 3'(dy >> SCALE_LOG2);
        s1_nx.col  = 3'(dx >> SCALE_LOG2);
        for (int k = 0; k < NUM_REGS; k++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (row == 3'(k) && dig == 3'(d)) begin
                    s1_nx.nib = snap[k][(DIGITS-1-d)*4 +: 4];
`ifdef VGA_REG_BANK_CHANGE_HL_EN
                    s1_nx.hl = hold[k][DIGITS-1-d] != 4'd0;
`endif
                end
            end
        end
    end

    always_ff @(posedge px_clk) begin
        if (!rst_n)
            s1 <= '0;
        else
            s1 <= s1_nx;
    end

    // Glyph rows top to bottom, MSB byte is row 0, bit 7 the leftmost pixel.
    always_comb begin
        glyph = '0;
        unique case (s1.nib)
            4'h0: glyph = 64'h3C666E7666663C00;
            4'h1: glyph = 64'h1838181818187E00;
            4'h2: glyph = 64'h3C66060C30607E00;
            4'h3: glyph = 64'h3C66061C06663C00;
            4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
            4'h5: glyph = 64'h7E607C0606663C00;
            4'h6: glyph = 64'h3C607C6666663C00;
            4'h7: glyph = 64'h7E060C1830303000;
            4'h8: glyph = 64'h3C66663C66663C00;
            4'h9: glyph = 64'h3C66663E060C3800;
            4'hA: glyph = 64'h183C66667E666600;
            4'hB: glyph = 64'h7C66667C66667C00;
            4'hC: glyph = 64'h3C66606060663C00;
            4'hD: glyph = 64'h786C6666666C7800;
            4'hE: glyph = 64'h7E60607C60607E00;
            4'hF: glyph = 64'h7E60607C60606000;
        endcase
    end

    assign bits = glyph[{3'd7 - s1.line, 3'd0} +: 8];
    assign on   = bits[3'd7 - s1.col];

    always_comb begin
        color = s1.rgb;
        if (s1.hit) begin
            if (on)
                color = s1.hl ? HL_COLOR : FG_COLOR;
            else
                color = OPAQUE ? BG_COLOR : s1.rgb;
        end
    end

    always_ff @(posedge px_clk) begin
        if (!rst_n)
            strRGB_o <= '0;
        else
            strRGB_o <= {s1.vga, color};
    end

endmodule

// File: tb/tb_vga_reg_bank.sv
// tb_vga_reg_bank: random pixel stream into two differently configured overlays,
// compared cycle by cycle with a frame-level text rendering model.
module tb_vga_reg_bank;

    logic        px_clk = 1'b0;
    logic        rst_n;
    logic [25:0] strRGB_i;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [63:0] regs0;
    logic [29:0] regs1;
    logic [25:0] out0;
    logic [25:0] out1;
    logic        snap0;
    logic        snap1;

    always #5 px_clk = ~px_clk;

    vga_reg_bank #(
        .NUM_REGS(4), .REG_WIDTH(16), .SCALE_LOG2(0),
        .FG_COLOR(3'b111), .BG_COLOR(3'b001), .OPAQUE(1'b1)
    ) dut0 (
        .px_clk(px_clk), .rst_n(rst_n), .strRGB_i(strRGB_i),
        .x_pos(x_pos), .y_pos(y_pos), .regs_i(regs0),
        .strRGB_o(out0), .snap_o(snap0)
    );

    vga_reg_bank #(
        .NUM_REGS(3), .REG_WIDTH(10), .SCALE_LOG2(1),
        .FG_COLOR(3'b101), .BG_COLOR(3'b011), .OPAQUE(1'b0)
    ) dut1 (
        .px_clk(px_clk), .rst_n(rst_n), .strRGB_i(strRGB_i),
        .x_pos(x_pos), .y_pos(y_pos), .regs_i(regs1),
        .strRGB_o(out1), .snap_o(snap1)
    );

    int         checks = 0;
    int         errors = 0;
    int         snap_seen = 0;

    int         c_nr  [2] = '{4, 3};
    int         c_rw  [2] = '{16, 10};
    int         c_sl  [2] = '{0, 1};
    bit         c_opq [2] = '{1'b1, 1'b0};
    logic [2:0] c_fg  [2] = '{3'b111, 3'b101};
    logic [2:0] c_bg  [2] = '{3'b001, 3'b011};

    logic [63:0] font [16];

    int unsigned m_snap [2][8];
    int          m_hold [2][8][8];
    int          m_xp [2];
    int          m_yp [2];
    logic [25:0] m_s1 [2];
    logic [25:0] m_out [2];
    bit          m_snap_o;
    bit          m_vsp;

    int xs [6] = '{100, 620, 1010, 0, 300, 7};
    int ys [6] = '{50, 476, 200, 1015, 470, 0};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int unsigned get_reg(int u, int k);
        if (u == 0)
            return int'(regs0[k*16 +: 16]);
        return int'(regs1[k*10 +: 10]);
    endfunction

    function automatic logic [2:0] expect_rgb(int u, logic [25:0] in);
        int x, y, s, dg, w, h, dx, dy, r, d, nib;
        bit on, hl;
        x  = int'(in[12:3]);
        y  = int'(in[22:13]);
        s  = 1 << c_sl[u];
        dg = (c_rw[u] + 3) / 4;
        w  = dg * 8 * s;
        h  = c_nr[u] * 8 * s;
        if (!in[25] || x < m_xp[u] || x >= m_xp[u] + w
            || y < m_yp[u] || y >= m_yp[u] + h)
            return in[2:0];
        dx  = x - m_xp[u];
        dy  = y - m_yp[u];
        r   = dy / (8 * s);
        d   = dx / (8 * s);
        nib = int'((m_snap[u][r] >> (4 * (dg - 1 - d))) & 15);
        on  = font[nib][63 - 8 * ((dy / s) % 8) - (dx / s) % 8];
        hl  = 1'b0;
`ifdef VGA_REG_BANK_CHANGE_HL_EN
        hl = m_hold[u][r][d] > 0;
`endif
        if (on)
            return hl ? 3'b110 : c_fg[u];
        return c_opq[u] ? c_bg[u] : in[2:0];
    endfunction

    task automatic take_snapshot(int u);
        int dg;
        int unsigned nv;
        dg = (c_rw[u] + 3) / 4;
        for (int k = 0; k < c_nr[u]; k++) begin
            nv = get_reg(u, k);
`ifdef VGA_REG_BANK_CHANGE_HL_EN
            for (int d = 0; d < dg; d++) begin
                if (((nv >> (4*(dg-1-d))) & 15) != ((m_snap[u][k] >> (4*(dg-1-d))) & 15))
                    m_hold[u][k][d] = 15;
                else if (m_hold[u][k][d] > 0)
                    m_hold[u][k][d]--;
            end
`endif
            m_snap[u][k] = nv;
        end
        m_xp[u] = int'(x_pos);
        m_yp[u] = int'(y_pos);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 8; k++) begin
                m_snap[u][k] = 0;
                for (int d = 0; d < 8; d++)
                    m_hold[u][k][d] = 0;
            end
            m_xp[u]  = 0;
            m_yp[u]  = 0;
            m_s1[u]  = '0;
            m_out[u] = '0;
        end
        m_snap_o = 1'b0;
        m_vsp    = 1'b0;
    endtask

    task automatic model_step();
        bit rise;
        if (!rst_n) begin
            model_reset();
        end else begin
            rise = strRGB_i[24] && !m_vsp;
            for (int u = 0; u < 2; u++) begin
                m_out[u] = m_s1[u];
                m_s1[u]  = {strRGB_i[25:3], expect_rgb(u, strRGB_i)};
            end
            m_snap_o = rise;
            m_vsp    = strRGB_i[24];
            if (rise) begin
                take_snapshot(0);
                take_snapshot(1);
            end
        end
    endtask

    task automatic cycle();
        @(posedge px_clk);
        model_step();
        @(negedge px_clk);
        check("out0", 32'(out0), 32'(m_out[0]));
        check("out1", 32'(out1), 32'(m_out[1]));
        check("snap0", 32'(snap0), 32'(m_snap_o));
        check("snap1", 32'(snap1), 32'(m_snap_o));
        if (snap0)
            snap_seen++;
    endtask

    task automatic drive_pixel(input bit vs);
        int unsigned x, y;
        if ($urandom_range(0, 9) == 0) begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
        end else begin
            x = (int'(m_xp[0]) + $urandom_range(0, 64) - 8) & 1023;
            y = (int'(m_yp[0]) + $urandom_range(0, 56) - 4) & 1023;
        end
        strRGB_i = {($urandom_range(0, 9) != 0), vs, 1'($urandom_range(0, 1)),
                    10'(y), 10'(x), 3'($urandom)};
    endtask

    task automatic new_regs();
        regs0 = {$urandom, $urandom};
        regs1 = 30'($urandom);
    endtask

    initial begin
        font[0]  = 64'h3C666E7666663C00;
        font[1]  = 64'h1838181818187E00;
        font[2]  = 64'h3C66060C30607E00;
        font[3]  = 64'h3C66061C06663C00;
        font[4]  = 64'h0C1C3C6C7E0C0C00;
        font[5]  = 64'h7E607C0606663C00;
        font[6]  = 64'h3C607C6666663C00;
        font[7]  = 64'h7E060C1830303000;
        font[8]  = 64'h3C66663C66663C00;
        font[9]  = 64'h3C66663E060C3800;
        font[10] = 64'h183C66667E666600;
        font[11] = 64'h7C66667C66667C00;
        font[12] = 64'h3C66606060663C00;
        font[13] = 64'h786C6666666C7800;
        font[14] = 64'h7E60607C60607E00;
        font[15] = 64'h7E60607C60606000;
        model_reset();

        rst_n    = 1'b0;
        strRGB_i = '0;
        x_pos    = '0;
        y_pos    = '0;
        regs0    = '0;
        regs1    = '0;
        repeat (3) begin
            drive_pixel(1'b0);
            cycle();
        end
        rst_n = 1'b1;

        for (int f = 0; f < 40; f++) begin
            if (f % 7 == 6) begin
                x_pos = 10'($urandom);
                y_pos = 10'($urandom);
            end else begin
                x_pos = 10'(xs[f % 6]);
                y_pos = 10'(ys[f % 6]);
            end
            if (f == 0)
                regs0 = 64'h1234_ABCD_0019_FFFF;
            else if ($urandom_range(0, 1) == 1)
                new_regs();
            for (int i = 0; i < 3; i++) begin
                drive_pixel(1'b1);
                cycle();
            end
            for (int i = 0; i < 250; i++) begin
                if (i == 100 && f % 3 == 1) begin
                    new_regs();
                    x_pos = 10'($urandom);
                    y_pos = 10'($urandom);
                end
                rst_n = !(f == 20 && i >= 120 && i < 123);
                drive_pixel(1'b0);
                cycle();
            end
        end
        repeat (3) begin
            drive_pixel(1'b0);
            cycle();
        end
        check("snap_count", 32'(snap_seen), 32'd40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
